// File: rtl/fifo_ctrl_if.sv
// FIFO stream interface: write side, read side, status flags.
// slave = FIFO side, master = producer/consumer side.
interface fifo_ctrl_if #(
  parameter int DATA = 16,
  parameter int ADDR = 5
);
  logic            wr_EN;
  logic [DATA-1:0] wr_DATA;
  logic            full;
  logic            almost_full;
  logic            rd_EN;
  logic [DATA-1:0] rd_DATA;
  logic            rd_VALID;
  logic            empty;
  logic            almost_empty;
  logic [ADDR:0]   count;
`ifdef FIFO_ERR_FLAG_EN
  logic            ovf_ERR;
  logic            udf_ERR;
  logic            err_CLR;

  modport slave (
    input  wr_EN, wr_DATA, rd_EN, err_CLR,
    output full, almost_full, rd_DATA, rd_VALID,
    output empty, almost_empty, count,
    output ovf_ERR, udf_ERR
  );

  modport master (
    output wr_EN, wr_DATA, rd_EN, err_CLR,
    input  full, almost_full, rd_DATA, rd_VALID,
    input  empty, almost_empty, count,
    input  ovf_ERR, udf_ERR
  );
`else
  modport slave (
    input  wr_EN, wr_DATA, rd_EN,
    output full, almost_full, rd_DATA, rd_VALID,
    output empty, almost_empty, count
  );

  modport master (
    output wr_EN, wr_DATA, rd_EN,
    input  full, almost_full, rd_DATA, rd_VALID,
    input  empty, almost_empty, count
  );
`endif
endinterface

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO over a dual-port RAM; port A writes, port B reads.
// Ports: clK, rsT (async, high), bus (fifo_ctrl_if.slave). Option: FIFO_ERR_FLAG_EN.
module dpram #(
  parameter int DATA = 16,
  parameter int ADDR = 5
) (
  input  logic            clk,
  input  logic            a_port_WR,
  input  logic [ADDR-1:0] a_port_ADDR,
  input  logic [DATA-1:0] a_port_data_IN,
  output logic [DATA-1:0] a_port_data_OUT,
  input  logic            b_port_WR,
  input  logic [ADDR-1:0] b_port_ADDR,
  input  logic [DATA-1:0] b_port_data_IN,
  output logic [DATA-1:0] b_port_data_OUT
);
  logic [DATA-1:0] mem_q [2**ADDR];
  logic [DATA-1:0] a_dout_q;
  logic [DATA-1:0] b_dout_q;

  always_ff @(posedge clk) begin
    if (a_port_WR) mem_q[a_port_ADDR] <= a_port_data_IN;
    if (b_port_WR) mem_q[b_port_ADDR] <= b_port_data_IN;
    a_dout_q <= mem_q[a_port_ADDR];
    b_dout_q <= mem_q[b_port_ADDR];
  end

  assign a_port_data_OUT = a_dout_q;
  assign b_port_data_OUT = b_dout_q;
endmodule

module fifo_ctrl #(
  parameter int DATA     = 16,
  parameter int ADDR     = 5,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input logic        clK,
  input logic        rsT,
  fifo_ctrl_if.slave bus
);
  localparam logic [ADDR:0] ONE  = (ADDR+1)'(1);
  localparam logic [ADDR:0] FULL = (ADDR+1)'(2**ADDR);
  localparam logic [ADDR:0] AF   = (ADDR+1)'(AF_LEVEL);
  localparam logic [ADDR:0] AE   = (ADDR+1)'(AE_LEVEL);

  logic [ADDR:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR:0]   count_q, count_d;
  logic            full_q, afull_q;
  logic            empty_q, aempty_q;
  logic            valid_q;
  logic            wr_acc, rd_acc;
  logic [DATA-1:0] b_dout;
  logic [DATA-1:0] unused_a_dout;

  // Requests are gated by the current flags only, so a same-cycle
  // pop never frees room for a push at full (and vice versa).
  assign wr_acc = bus.wr_EN & ~full_q;
  assign rd_acc = bus.rd_EN & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clK or posedge rsT) begin
    if (rsT) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == FULL);
      afull_q  <= (count_d >= AF);
      empty_q  <= (count_d == '0);
      aempty_q <= (count_d <= AE);
      valid_q  <= rd_acc;
    end
  end

  // Wrap-extended pointers must always differ by exactly the count.
  always_ff @(posedge clK) begin
    if (!rsT) assert (count_q == wr_ptr_q - rd_ptr_q);
  end

  dpram #(
    .DATA (DATA),
    .ADDR (ADDR)
  ) u_ram (
    .clk             (clK),
    .a_port_WR       (wr_acc),
    .a_port_ADDR     (wr_ptr_q[ADDR-1:0]),
    .a_port_data_IN  (bus.wr_DATA),
    .a_port_data_OUT (unused_a_dout),
    .b_port_WR       (1'b0),
    .b_port_ADDR     (rd_ptr_q[ADDR-1:0]),
    .b_port_data_IN  ('0),
    .b_port_data_OUT (b_dout)
  );

  assign bus.full         = full_q;
  assign bus.almost_full  = afull_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.rd_VALID     = valid_q;
  assign bus.rd_DATA      = b_dout;

`ifdef FIFO_ERR_FLAG_EN
  logic ovf_q, udf_q;

  // Sticky; clear wins over a same-cycle set.
  always_ff @(posedge clK or posedge rsT) begin
    if (rsT) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (bus.err_CLR) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wr_EN & full_q)  ovf_q <= 1'b1;
      if (bus.rd_EN & empty_q) udf_q <= 1'b1;
    end
  end

  assign bus.ovf_ERR = ovf_q;
  assign bus.udf_ERR = udf_q;
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized + directed bench for fifo_ctrl against a queue model.
// Model: queue of stored words, pending read word, sticky error bits.
module tb_fifo_ctrl;
  localparam int DATA  = 16;
  localparam int ADDR  = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  fifo_ctrl_if #(.DATA(DATA), .ADDR(ADDR)) bus ();

  fifo_ctrl #(
    .DATA     (DATA),
    .ADDR     (ADDR),
    .AF_LEVEL (28),
    .AE_LEVEL (4)
  ) dut (
    .clK (clk),
    .rsT (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DATA-1:0] q[$];
  logic            m_valid = 1'b0;
  logic [DATA-1:0] m_data  = '0;
  logic            m_ovf   = 1'b0;
  logic            m_udf   = 1'b0;
  logic            clr     = 1'b0;

`ifdef FIFO_ERR_FLAG_EN
  assign bus.err_CLR = clr;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    chk("count", 32'(bus.count), n);
    chk("empty", 32'(bus.empty), 32'(n == 0));
    chk("full", 32'(bus.full), 32'(n == DEPTH));
    chk("afull", 32'(bus.almost_full), 32'(n >= 28));
    chk("aempty", 32'(bus.almost_empty), 32'(n <= 4));
    chk("valid", 32'(bus.rd_VALID), 32'(m_valid));
    if (m_valid) chk("data", 32'(bus.rd_DATA), 32'(m_data));
`ifdef FIFO_ERR_FLAG_EN
    chk("ovf", 32'(bus.ovf_ERR), 32'(m_ovf));
    chk("udf", 32'(bus.udf_ERR), 32'(m_udf));
`endif
  endtask

  // One clock: drive, advance model, compare on the falling edge.
  task automatic step(input logic w, input logic r,
                      input logic [DATA-1:0] d);
    bit was_full  = (q.size() == DEPTH);
    bit was_empty = (q.size() == 0);
    bus.wr_EN   = w;
    bus.rd_EN   = r;
    bus.wr_DATA = d;
    m_valid = r && !was_empty;
    if (m_valid) m_data = q.pop_front();
    if (w && !was_full) q.push_back(d);
    if (clr) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bus.wr_EN   = 1'b0;
    bus.rd_EN   = 1'b0;
    bus.wr_DATA = '0;
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    for (int i = 0; i < 33; i++) step(1'b1, 1'b0, 16'(i));
    for (int i = 0; i < 33; i++) step(1'b0, 1'b1, 16'hFFFF);

    clr = 1'b1;
    step(1'b0, 1'b0, '0);
    clr = 1'b0;

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 16'($urandom));
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, '0);
    end

    step(1'b1, 1'b1, 16'hA5A5);
    for (int i = 0; i < 31; i++) step(1'b1, 1'b0, 16'($urandom));
    step(1'b1, 1'b1, 16'h5A5A);
    for (int i = 0; i < 26; i++) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 16'h1234);

    clr = 1'b1;
    step(1'b0, 1'b1, '0);
    clr = 1'b0;

    while (q.size() < 11) step(1'b1, 1'b0, 16'($urandom));
    while (q.size() > 11) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    rst = 1'b1;
    #1;
    q.delete();
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_valid", 32'(bus.rd_VALID), 0);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    for (int ph = 0; ph < 4; ph++) begin
      int wp;
      case (ph)
        0:       wp = 75;
        1:       wp = 25;
        2:       wp = 50;
        default: wp = 90;
      endcase
      for (int i = 0; i < 400; i++) begin
        clr = ($urandom_range(0, 99) < 4);
        step($urandom_range(0, 99) < wp,
             $urandom_range(0, 99) < 100 - wp + 10,
             16'($urandom));
      end
    end
    clr = 1'b0;
    bus.wr_EN = 1'b0;
    bus.rd_EN = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
